serial_seq_ctrl: RTL and testbench

Word-level controller for the team's serial 10101 sequence detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an embedded 5-state Mealy detector. It selects overlapping or non-overlapping detection per word and keeps a saturating match count. It sits between a parallel producer (bus or FIFO) and status logic that reads match events and counts.

---
 rtl/serial_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_ctrl.sv
// serial_seq_ctrl
// Word-level front end for the 10101 serial sequence detector. Parallel words
// arrive over a valid/ready handshake and are shifted out MSB-first into an
// embedded 5-state Mealy detector. Overlapping or non-overlapping detection
// is chosen per word. A saturating counter tracks the number of matches.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   producer presents a word on in_data
//   in_data    word to serialize, MSB first
//   in_ready   a word can be accepted (IDLE only)
//   overlap    detection mode, sampled when a word is accepted
//   clr_cnt    synchronous clear of match_cnt (wins over a simultaneous match)
//   ser_bit    bit currently fed to the detector (0 when idle)
//   ser_valid  ser_bit is valid this cycle
//   match      combinational Mealy match flag
//   word_done  one-cycle pulse after the last bit of a word
//   match_cnt  saturating match count
//   busy       high while shifting or finishing a word
module serial_seq_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              overlap,
  input  logic              clr_cnt,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match,
  output logic              word_done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy
);

  localparam int BCW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_t;

  ctrl_t             state;
  det_t              det;
  det_t              det_next;
  logic [WORD_W-1:0] shift_reg;
  logic [BCW-1:0]    bit_cnt;
  logic              mode_q;

  assign in_ready  = (state == ST_IDLE);
  assign ser_valid = (state == ST_SHIFT);
  assign word_done = (state == ST_DONE);
  assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
  assign ser_bit   = ser_valid & shift_reg[WORD_W-1];
  assign match     = ser_valid & (det == S4) & ser_bit;

  // Detector next state. Legal states hold while no bit is presented;
  // any unused encoding falls through to S0 regardless of ser_valid.
  always_comb begin
    det_next = S0;
    case (det)
      S0: det_next = !ser_valid ? S0 : (ser_bit ? S1 : S0);
      S1: det_next = !ser_valid ? S1 : (ser_bit ? S1 : S2);
      S2: det_next = !ser_valid ? S2 : (ser_bit ? S3 : S0);
      S3: det_next = !ser_valid ? S3 : (ser_bit ? S1 : S4);
      S4: begin
        if (!ser_valid)   det_next = S4;
        else if (ser_bit) det_next = mode_q ? S3 : S0;
        else              det_next = S0;
      end
      default: det_next = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      det       <= S0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      mode_q    <= 1'b0;
    end else begin
      det <= det_next;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            bit_cnt   <= BCW'(WORD_W - 1);
            mode_q    <= overlap;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          if (bit_cnt == '0) begin
            state <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Scoreboard bench for serial_seq_ctrl. Two instances share all stimulus:
// one with an 8-bit counter and one with a 2-bit counter for saturation.
// Expected bits/matches/counts come from a suffix-history model of the
// 10101 search and are queued at accept time; a negedge monitor pops them.
module tb_serial_seq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         overlap  = 1'b0;
  logic         clr_cnt  = 1'b0;

  logic       in_ready, ser_bit, ser_valid, match, word_done, busy;
  logic [7:0] match_cnt;
  logic       d2_in_ready, d2_ser_bit, d2_ser_valid, d2_match, d2_word_done, d2_busy;
  logic [1:0] d2_match_cnt;

  serial_seq_ctrl #(.WORD_W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .overlap(overlap), .clr_cnt(clr_cnt),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .match(match),
    .word_done(word_done), .match_cnt(match_cnt), .busy(busy)
  );

  serial_seq_ctrl #(.WORD_W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(d2_in_ready), .overlap(overlap), .clr_cnt(clr_cnt),
    .ser_bit(d2_ser_bit), .ser_valid(d2_ser_valid), .match(d2_match),
    .word_done(d2_word_done), .match_cnt(d2_match_cnt), .busy(d2_busy)
  );

  typedef struct {
    logic sb;
    logic m;
  } bit_exp_t;

  bit_exp_t q_bits[$];
  int       q_cnt8[$];
  int       q_cnt2[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: recent bit history since reset or the last consumed match.
  logic [4:0] hist;
  int         hlen;
  int         cnt8;
  int         cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist = '0;
    hlen = 0;
    cnt8 = 0;
    cnt2 = 0;
  endfunction

  function automatic logic model_bit(input logic b, input logic ov, input logic clr);
    logic m;
    hist = {hist[3:0], b};
    if (hlen < 5) hlen++;
    m = (hlen >= 5) && (hist == 5'b10101);
    // Non-overlapping: bits that formed a match cannot start another one.
    if (m && !ov) hlen = 0;
    if (clr) begin
      cnt8 = 0;
      cnt2 = 0;
    end else if (m) begin
      if (cnt8 < 255) cnt8++;
      if (cnt2 < 3)   cnt2++;
    end
    return m;
  endfunction

  // Present a word, wait for accept, then walk nb of its bit cycles.
  // Returns at #1 after the edge that ends the last walked bit.
  task automatic send_word(input logic [W-1:0] d, input logic ov, input int clr_bit, input int nb);
    int t;
    logic b, m;
    in_valid = 1'b1;
    in_data  = d;
    overlap  = ov;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nb; i++) begin
      b = d[W-1-i];
      m = model_bit(b, ov, (i == clr_bit));
      q_bits.push_back('{sb: b, m: m});
    end
    if (nb == W) begin
      q_cnt8.push_back(cnt8);
      q_cnt2.push_back(cnt2);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    overlap  = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      clr_cnt = (i == clr_bit);
      @(posedge clk); #1;
    end
    clr_cnt = 1'b0;
    if (nb == W) begin
      check("word_done_after_last_bit", word_done, 1);
      check("in_ready_low_in_done", in_ready, 0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_bit", ser_bit, 0);
    check("rst_match", match, 0);
    check("rst_word_done", word_done, 0);
    check("rst_busy", busy, 0);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_match_cnt2", d2_match_cnt, 0);
  endtask

  task automatic do_reset(input logic settle_first);
    if (settle_first) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    q_bits.delete();
    q_cnt8.delete();
    q_cnt2.delete();
    model_reset();
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_match_cnt", match_cnt, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    bit_exp_t e;
    int c8, c2;
    forever begin
      @(negedge clk);
      if (ser_valid) begin
        if (q_bits.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bit: ser_valid=1 with nothing expected at %0t", $time);
        end else begin
          e = q_bits.pop_front();
          check("ser_bit", ser_bit, e.sb);
          check("match", match, e.m);
        end
      end else begin
        check("idle_ser_bit", ser_bit, 0);
        check("idle_match", match, 0);
      end
      if (word_done) begin
        if (q_cnt8.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word_done: pulse with no word pending at %0t", $time);
        end else begin
          c8 = q_cnt8.pop_front();
          c2 = q_cnt2.pop_front();
          check("match_cnt", match_cnt, c8);
          check("match_cnt_sat2", d2_match_cnt, c2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pick[5];
    logic [W-1:0] d;
    int gap, cb;
    model_reset();
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("init_in_ready", in_ready, 1);
    check("init_match_cnt", match_cnt, 0);
    @(posedge clk); #1;

    // Single non-overlapping match; idle cycle then in_ready back high.
    send_word(8'hA8, 1'b0, -1, W);
    @(posedge clk); #1;
    check("in_ready_after_done", in_ready, 1);

    send_word(8'hAA, 1'b1, -1, W);
    do_reset(1'b1);
    send_word(8'hAA, 1'b0, -1, W);
    do_reset(1'b1);

    // Pattern spanning a word boundary.
    send_word(8'h0A, 1'b0, -1, W);
    send_word(8'h80, 1'b0, -1, W);
    do_reset(1'b1);

    // Narrow counter saturates; then clear in the match cycle wins.
    for (int k = 0; k < 5; k++) send_word(8'hA8, 1'b0, -1, W);
    send_word(8'hA8, 1'b0, 4, W);

    // Reset while a word is partly shifted, then a fresh word.
    send_word(8'hAA, 1'b0, -1, 4);
    do_reset(1'b0);
    send_word(8'h15, 1'b0, -1, W);

    // Randomized traffic biased towards pattern-rich words.
    pick[0] = 8'hAA; pick[1] = 8'h55; pick[2] = 8'hA8; pick[3] = 8'h15; pick[4] = 8'h2A;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 0) d = pick[$urandom_range(0, 4)];
      else                           d = W'($urandom);
      cb  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
        check("in_ready_idle_gap", in_ready, 1);
      end
      send_word(d, 1'($urandom), cb, W);
    end

    repeat (3) @(posedge clk);
    #1;
    check("bits_drained", q_bits.size(), 0);
    check("counts_drained", q_cnt8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
